// File: rtl/fork_join_tracker_if.sv
// Launch/observe bundle between a sequencer and the fork/join tracker.
interface fork_join_tracker_if #(
   parameter int NUM_TASKS = 3,
   parameter int DLY_W     = 8,
   parameter int ID_W      = 4
);
   logic                       start;
   logic [NUM_TASKS-1:0]       task_en;
   logic [NUM_TASKS*DLY_W-1:0] delay_i;
   logic [1:0]                 join_mode;
   logic                       busy;
   logic [NUM_TASKS-1:0]       active;
   logic [NUM_TASKS-1:0]       task_done;
   logic                       join_release;
   logic [ID_W-1:0]            first_id;
   logic                       all_done;
   logic                       start_err;

   modport master (
      output start, task_en, delay_i, join_mode,
      input  busy, active, task_done, join_release, first_id, all_done, start_err
   );

   modport slave (
      input  start, task_en, delay_i, join_mode,
      output busy, active, task_done, join_release, first_id, all_done, start_err
   );
endinterface

// File: rtl/fork_join_tracker.sv
// Launches up to NUM_TASKS parallel countdowns per start and reports join/all-done events.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | no launch in flight, start accepted here
// S_WAIT_JOIN | tasks running, join condition (all or any) not yet met
// S_WAIT_ALL  | join released, waiting for the remaining tasks to finish
module fork_join_tracker #(
   parameter int NUM_TASKS = 3,
   parameter int DLY_W     = 8,
   parameter int ID_W      = 4
) (
   input logic                clk,
   input logic                rst_n,
   fork_join_tracker_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_JOIN = 2'd1,
      S_WAIT_ALL  = 2'd2
   } state_t;

   localparam logic [1:0] MODE_ANY  = 2'd1;
   localparam logic [1:0] MODE_NONE = 2'd2;

   state_t               state;
   logic [DLY_W-1:0]     cnt [NUM_TASKS];
   logic [NUM_TASKS-1:0] active_q;
   logic [NUM_TASKS-1:0] done_v;
   logic [NUM_TASKS-1:0] remain_v;
   logic                 any_q;
   logic                 rel_pend;
   logic                 start_err_q;
   logic [ID_W-1:0]      first_q;
   logic [ID_W-1:0]      enc_id;
   logic                 all_done_c;
   logic                 first_hit;
   logic                 release_c;

   always_comb begin
      done_v = '0;
      enc_id = '0;
      for (int i = 0; i < NUM_TASKS; i++) begin
         done_v[i] = active_q[i] && (cnt[i] == '0);
      end
      // Downward scan so the lowest completing index wins a tie.
      for (int i = NUM_TASKS - 1; i >= 0; i--) begin
         if (done_v[i]) enc_id = ID_W'(i);
      end
      remain_v   = active_q & ~done_v;
      all_done_c = (state != S_IDLE) && (remain_v == '0);
      first_hit  = (state == S_WAIT_JOIN) && any_q && ((|done_v) || all_done_c);
      release_c  = 1'b0;
      case (state)
         S_WAIT_JOIN: release_c = any_q ? first_hit : all_done_c;
         S_WAIT_ALL:  release_c = rel_pend;
         default:     release_c = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         active_q    <= '0;
         any_q       <= 1'b0;
         rel_pend    <= 1'b0;
         start_err_q <= 1'b0;
         first_q     <= '0;
         for (int i = 0; i < NUM_TASKS; i++) cnt[i] <= '0;
      end else begin
         start_err_q <= bus.start && (state != S_IDLE);
         rel_pend    <= 1'b0;

         for (int i = 0; i < NUM_TASKS; i++) begin
            if (active_q[i]) begin
               if (done_v[i]) active_q[i] <= 1'b0;
               else           cnt[i]      <= cnt[i] - 1'b1;
            end
         end

         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  for (int i = 0; i < NUM_TASKS; i++) begin
                     if (bus.task_en[i]) begin
                        active_q[i] <= 1'b1;
                        cnt[i]      <= bus.delay_i[i*DLY_W +: DLY_W];
                     end
                  end
                  any_q   <= (bus.join_mode == MODE_ANY);
                  first_q <= '0;
                  if (bus.join_mode == MODE_NONE) begin
                     state    <= S_WAIT_ALL;
                     rel_pend <= 1'b1;
                  end else begin
                     state <= S_WAIT_JOIN;
                  end
               end
            end
            S_WAIT_JOIN: begin
               if (first_hit) first_q <= enc_id;
               if (all_done_c)     state <= S_IDLE;
               else if (first_hit) state <= S_WAIT_ALL;
            end
            S_WAIT_ALL: begin
               if (all_done_c) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy         = (state != S_IDLE);
   assign bus.active       = active_q;
   assign bus.task_done    = done_v;
   assign bus.join_release = release_c;
   assign bus.first_id     = first_hit ? enc_id : first_q;
   assign bus.all_done     = all_done_c;
   assign bus.start_err    = start_err_q;

endmodule

// File: tb/tb_fork_join_tracker.sv
// Directed-vector bench for fork_join_tracker: per-cycle check of every output against hand-computed event times.
module tb_fork_join_tracker;
   localparam int NT = 3;
   localparam int DW = 8;
   localparam int IW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   fork_join_tracker_if #(.NUM_TASKS(NT), .DLY_W(DW), .ID_W(IW)) bus ();

   fork_join_tracker #(.NUM_TASKS(NT), .DLY_W(DW), .ID_W(IW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Vector layout: {start_err, busy, release, all_done, task_done[2:0], active[2:0]}
   task automatic run(input string name, input logic [2:0] mask, input int d0, input int d1,
                      input int d2, input logic [1:0] mode, input int rel_c, input int ad_c,
                      input int fid, input int err_c, input int rst_c);
      int dly [3];
      logic [9:0] exp_v;
      logic [9:0] got_v;
      dly[0] = d0; dly[1] = d1; dly[2] = d2;
      @(posedge clk); #1;
      bus.start     = 1'b1;
      bus.task_en   = mask;
      bus.delay_i   = {DW'(d2), DW'(d1), DW'(d0)};
      bus.join_mode = mode;
      for (int cyc = 0; cyc <= ad_c + 2; cyc++) begin
         @(negedge clk);
         exp_v = '0;
         if (!(rst_c >= 0 && cyc >= rst_c)) begin
            exp_v[9] = (err_c >= 0) && (cyc == err_c + 1);
            exp_v[8] = (cyc >= 1) && (cyc <= ad_c);
            exp_v[7] = (cyc == rel_c);
            exp_v[6] = (cyc == ad_c);
            for (int i = 0; i < 3; i++) begin
               exp_v[3+i] = mask[i] && (cyc == dly[i] + 1);
               exp_v[i]   = mask[i] && (cyc >= 1) && (cyc <= dly[i] + 1);
            end
         end
         got_v = {bus.start_err, bus.busy, bus.join_release, bus.all_done, bus.task_done, bus.active};
         check($sformatf("%s c%0d outs", name, cyc), 32'(got_v), 32'(exp_v));
         if (mode == 2'd1 && cyc >= rel_c) begin
            if (rst_c >= 0 && cyc >= rst_c)
               check($sformatf("%s c%0d first_id", name, cyc), 32'(bus.first_id), 32'd0);
            else
               check($sformatf("%s c%0d first_id", name, cyc), 32'(bus.first_id), 32'(fid));
         end
         @(posedge clk); #1;
         bus.start = (cyc + 1 == err_c);
         if (cyc + 1 == err_c) bus.delay_i = '0;
         if (rst_c >= 0 && cyc + 1 >= rst_c && cyc + 1 < rst_c + 2) rst_n = 1'b0;
         else rst_n = 1'b1;
      end
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.task_en   = '0;
      bus.delay_i   = '0;
      bus.join_mode = 2'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset outs", 32'({bus.start_err, bus.busy, bus.join_release, bus.all_done,
                               bus.task_done, bus.active, bus.first_id}), 32'd0);
      #1 rst_n = 1'b1;
      @(posedge clk);

      run("any",     3'b111, 30, 15, 10, 2'd1, 11, 31, 2, -1, -1);
      run("all",     3'b111, 30, 15, 10, 2'd0, 31, 31, 0, -1, -1);
      run("none",    3'b111,  5,  1,  0, 2'd2,  1,  6, 0, -1, -1);
      run("tie",     3'b111,  7,  7,  9, 2'd1,  8, 10, 0, -1, -1);
      run("busyst",  3'b111, 30, 15, 10, 2'd1, 11, 31, 2,  5, -1);
      run("zero",    3'b000,  4,  4,  4, 2'd0,  1,  1, 0, -1, -1);
      run("zeroany", 3'b000,  4,  4,  4, 2'd1,  1,  1, 0, -1, -1);
      run("rsvd",    3'b011,  2,  6,  9, 2'd3,  7,  7, 0, -1, -1);
      run("maxdly",  3'b101, 255, 9,  3, 2'd0, 256, 256, 0, -1, -1);
      run("reset",   3'b111, 30, 15, 10, 2'd1, 11, 31, 2, -1, 12);
      run("again",   3'b111, 30, 15, 10, 2'd1, 11, 31, 2, -1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
